// File: rtl/restoring_divider_core_if.sv
// -----------------------------------------------------------------------------
// restoring_divider_core_if
//   Start/done handshake bundle between the operand source and the restoring
//   divider core.
//
//   Parameter
//     N          divisor/quotient/remainder width; dividend is 2N bits
//
//   Signals
//     start      request a division (source -> core)
//     dividend   2N-bit dividend   (source -> core)
//     divisor    N-bit divisor     (source -> core)
//     busy       operation in flight (core -> source)
//     done       one-cycle result strobe (core -> source)
//     quotient   N-bit quotient    (core -> source)
//     remainder  N-bit remainder   (core -> source)
//     ovf        overflow / divide-by-zero flag (core -> source)
//
//   Modports
//     master     the operand source / result consumer
//     slave      the divider core
// -----------------------------------------------------------------------------
interface restoring_divider_core_if #(
    parameter int N = 5
);
    logic             start;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             busy;
    logic             done;
    logic [N-1:0]     quotient;
    logic [N-1:0]     remainder;
    logic             ovf;

    modport master (
        output start,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  ovf
    );

    modport slave (
        input  start,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output ovf
    );
endinterface

// File: rtl/restoring_divider_core.sv
// -----------------------------------------------------------------------------
// restoring_divider_core
//   Sequential restoring divider: 2N-bit dividend / N-bit divisor giving an
//   N-bit quotient and N-bit remainder. Holds the controlling FSM and the A/Q/D
//   datapath:
//     A  N+1-bit partial remainder
//     Q  N-bit shift register (load / shift-left / serial-in of quotient bits)
//     D  N-bit divisor
//
//   Sequence: IDLE -> LOAD -> {SHIFT -> SUB} x N -> DONE -> IDLE.
//   With start sampled at edge k, busy is high from the next cycle through
//   the DONE cycle (2N+2 cycles) and done pulses in the DONE cycle, together
//   with the freshly registered quotient/remainder/ovf.
//
//   Ports
//     clk        system clock, all state updates on posedge
//     rst        synchronous active-high reset; dominates start
//     bus        restoring_divider_core_if.slave handshake bundle
//                (start, dividend, divisor in; busy, done, quotient,
//                 remainder, ovf out)
//
//   Build option
//     DIV_OVF_CHECK_EN  when defined, LOAD detects divisor==0 or a high
//                       dividend half >= divisor, skips the iterations and
//                       finishes with ovf=1, quotient=0, remainder=0.
//                       When undefined, every operand runs all N iterations
//                       and ovf is held at 0.
// -----------------------------------------------------------------------------
module restoring_divider_core #(
    parameter int N = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    restoring_divider_core_if.slave    bus
);

    localparam int CW = $clog2(N + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_SUB   = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Unsigned N+1-bit trial subtraction; bit N set means the result went negative.
    function automatic logic [N:0] trial_sub(input logic [N:0] a, input logic [N-1:0] d);
        return a - {1'b0, d};
    endfunction

    state_t            state_r;
    logic [2*N-1:0]    dvd_in_r;
    logic [N-1:0]      dvs_in_r;
    logic [N:0]        a_r;
    logic [N-1:0]      q_r;
    logic [N-1:0]      d_r;
    logic [CW-1:0]     count_r;
    logic              busy_r;
    logic              done_r;
    logic [N-1:0]      quotient_r;
    logic [N-1:0]      remainder_r;
    logic              ovf_r;

    logic [N:0]        t_s;
    logic [N:0]        a_sub_s;
    logic [N-1:0]      q_sub_s;

`ifdef DIV_OVF_CHECK_EN
    logic              ovf_s;

    // A quotient that cannot fit in N bits (or a zero divisor) is flagged up front.
    always_comb begin
        if ((dvs_in_r == {N{1'b0}}) || (dvd_in_r[2*N-1:N] >= dvs_in_r)) begin
            ovf_s = 1'b1;
        end else begin
            ovf_s = 1'b0;
        end
    end
`endif

    // SUB-step result: keep the difference when non-negative, otherwise restore A.
    always_comb begin
        t_s = trial_sub(a_r, d_r);
        if (t_s[N]) begin
            a_sub_s = a_r;
            q_sub_s = {q_r[N-1:1], 1'b0};
        end else begin
            a_sub_s = t_s;
            q_sub_s = {q_r[N-1:1], 1'b1};
        end
    end

    // Controller and datapath; outputs are registered and change only when entering DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            dvd_in_r    <= {(2*N){1'b0}};
            dvs_in_r    <= {N{1'b0}};
            a_r         <= {(N+1){1'b0}};
            q_r         <= {N{1'b0}};
            d_r         <= {N{1'b0}};
            count_r     <= {CW{1'b0}};
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            quotient_r  <= {N{1'b0}};
            remainder_r <= {N{1'b0}};
            ovf_r       <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (bus.start) begin
                        dvd_in_r <= bus.dividend;
                        dvs_in_r <= bus.divisor;
                        busy_r   <= 1'b1;
                        state_r  <= S_LOAD;
                    end else begin
                        state_r  <= S_IDLE;
                    end
                end

                S_LOAD: begin
                    a_r     <= {1'b0, dvd_in_r[2*N-1:N]};
                    q_r     <= dvd_in_r[N-1:0];
                    d_r     <= dvs_in_r;
                    count_r <= {CW{1'b0}};
`ifdef DIV_OVF_CHECK_EN
                    if (ovf_s) begin
                        quotient_r  <= {N{1'b0}};
                        remainder_r <= {N{1'b0}};
                        ovf_r       <= 1'b1;
                        done_r      <= 1'b1;
                        state_r     <= S_DONE;
                    end else begin
                        state_r     <= S_SHIFT;
                    end
`else
                    state_r <= S_SHIFT;
`endif
                end

                S_SHIFT: begin
                    // {A,Q} shifts left as one 2N+1-bit register; the vacated Q[0] takes 0.
                    {a_r, q_r} <= {a_r[N-1:0], q_r, 1'b0};
                    state_r    <= S_SUB;
                end

                S_SUB: begin
                    a_r     <= a_sub_s;
                    q_r     <= q_sub_s;
                    count_r <= count_r + CW'(1);
                    if (count_r == CW'(N - 1)) begin
                        // Last iteration: publish the result so it is valid throughout DONE.
                        quotient_r  <= q_sub_s;
                        remainder_r <= a_sub_s[N-1:0];
                        ovf_r       <= 1'b0;
                        done_r      <= 1'b1;
                        state_r     <= S_DONE;
                    end else begin
                        state_r     <= S_SHIFT;
                    end
                end

                S_DONE: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end

                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.quotient  = quotient_r;
    assign bus.remainder = remainder_r;
    assign bus.ovf       = ovf_r;

endmodule

// File: tb/tb_restoring_divider_core.sv
// -----------------------------------------------------------------------------
// tb_restoring_divider_core
//   Directed, table-driven bench for restoring_divider_core with N=5 and a
//   40 ns clock. Inputs change and outputs are sampled on the falling edge.
//   Cycle 1 is the cycle right after the edge that accepts start.
// -----------------------------------------------------------------------------
module tb_restoring_divider_core;
    localparam int N = 5;

    typedef struct {
        logic [2*N-1:0] dvd;
        logic [N-1:0]   dvs;
        logic [N-1:0]   q;
        logic [N-1:0]   r;
        logic           ovf;
        int             lat;
    } vec_t;

    logic clk = 1'b0;
    logic rst;

    restoring_divider_core_if #(.N(N)) bus ();

    restoring_divider_core #(.N(N)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #20 clk = ~clk;

    int   n_chk = 0;
    int   n_err = 0;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int dvd, input int dvs, input int q, input int r,
                                input int ovf, input int lat);
        vec_t v;
        v.dvd = dvd[2*N-1:0];
        v.dvs = dvs[N-1:0];
        v.q   = q[N-1:0];
        v.r   = r[N-1:0];
        v.ovf = ovf[0];
        v.lat = lat;
        return v;
    endfunction

    // Called on a falling edge while the core is idle; returns on the done cycle.
    task automatic run_op(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                          output int lat, output int bcnt);
        bus.start    = 1'b1;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat  = 1;
        bcnt = bus.busy ? 1 : 0;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (bus.busy) bcnt++;
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dcnt;

        tbl.push_back(mk(17,  5,  3,  2, 0, 12));
        tbl.push_back(mk(900, 31, 29, 1, 0, 12));
        tbl.push_back(mk(0,   7,  0,  0, 0, 12));
        tbl.push_back(mk(31,  1,  31, 0, 0, 12));
        tbl.push_back(mk(100, 7,  14, 2, 0, 12));
        tbl.push_back(mk(991, 31, 31, 30, 0, 12));
        tbl.push_back(mk(5,   6,  0,  5, 0, 12));
        tbl.push_back(mk(62,  2,  31, 0, 0, 12));
`ifdef DIV_OVF_CHECK_EN
        tbl.push_back(mk(17,  0,  0,  0, 1, 2));
        tbl.push_back(mk(200, 6,  0,  0, 1, 2));
`else
        tbl.push_back(mk(17,  0,  31, 17, 0, 12));
`endif
        tbl.push_back(mk(17,  5,  3,  2, 0, 12));

        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset busy", int'(bus.busy), 0);
        chk("reset done", int'(bus.done), 0);
        chk("reset quotient", int'(bus.quotient), 0);
        chk("reset remainder", int'(bus.remainder), 0);
        chk("reset ovf", int'(bus.ovf), 0);
        rst = 1'b0;

        // Table: each op starts in the idle cycle right after the previous done.
        foreach (tbl[i]) begin
            run_op(tbl[i].dvd, tbl[i].dvs, lat, bcnt);
            chk($sformatf("v%0d latency", i), lat, tbl[i].lat);
            chk($sformatf("v%0d busy cycles", i), bcnt, tbl[i].lat);
            chk($sformatf("v%0d quotient", i), int'(bus.quotient), int'(tbl[i].q));
            chk($sformatf("v%0d remainder", i), int'(bus.remainder), int'(tbl[i].r));
            chk($sformatf("v%0d ovf", i), int'(bus.ovf), int'(tbl[i].ovf));
            @(negedge clk);
            chk($sformatf("v%0d done pulse width", i), int'(bus.done), 0);
            chk($sformatf("v%0d busy after done", i), int'(bus.busy), 0);
            chk($sformatf("v%0d quotient held", i), int'(bus.quotient), int'(tbl[i].q));
        end

        // start raised at cycle 4 of an in-flight 17/5 must be ignored.
        bus.start    = 1'b1;
        bus.dividend = 10'd17;
        bus.divisor  = 5'd5;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        lat = 1;
        while (!bus.done && lat < 40) begin
            @(negedge clk);
            lat++;
            if (lat == 4) begin
                bus.start    = 1'b1;
                bus.dividend = 10'd900;
                bus.divisor  = 5'd31;
            end else begin
                bus.start = 1'b0;
            end
        end
        chk("ignored start latency", lat, 12);
        chk("ignored start quotient", int'(bus.quotient), 3);
        chk("ignored start remainder", int'(bus.remainder), 2);
        repeat (2) @(negedge clk);
        chk("ignored start not queued", int'(bus.busy), 0);

        // Reset at cycle 6 of 900/31 aborts with no done; then 17/5 runs clean.
        bus.start    = 1'b1;
        bus.dividend = 10'd900;
        bus.divisor  = 5'd31;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        dcnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.done) dcnt++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort busy", int'(bus.busy), 0);
        chk("abort done", int'(bus.done), 0);
        chk("abort quotient", int'(bus.quotient), 0);
        chk("abort remainder", int'(bus.remainder), 0);
        chk("abort ovf", int'(bus.ovf), 0);
        repeat (15) begin
            @(negedge clk);
            if (bus.done || bus.busy) dcnt++;
        end
        chk("abort no done", dcnt, 0);
        run_op(10'd17, 5'd5, lat, bcnt);
        chk("post-abort latency", lat, 12);
        chk("post-abort quotient", int'(bus.quotient), 3);
        chk("post-abort remainder", int'(bus.remainder), 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end
endmodule
